// File: rtl/acc_cpu_p_pkg.sv
// Shared constants for the parametrised accumulator CPU: opcodes, FSM state
// encoding (also the debug sc value) and ALU operation selects.
package acc_cpu_p_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JUMP = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_F0  = 3'd0,
    ST_F1  = 3'd1,
    ST_F2  = 3'd2,
    ST_DEC = 3'd3,
    ST_O1  = 3'd4,
    ST_O2  = 3'd5,
    ST_EX  = 3'd6,
    ST_HLT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'd0,
    ALU_PASS_B = 3'd1,
    ALU_INC    = 3'd2,
    ALU_ADD    = 3'd3,
    ALU_SUB    = 3'd4
  } alu_op_t;

  // Every defined opcode between LDI and JC carries an operand word.
  function automatic logic has_operand(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_JC);
  endfunction

endpackage

// File: rtl/acc_cpu_p_alu.sv
// Combinational ALU: (DW+1)-bit add/sub so carry/borrow falls out of the top bit.
module acc_cpu_p_alu
  import acc_cpu_p_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_t       op,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      ALU_PASS_A: wide = {1'b0, a};
      ALU_PASS_B: wide = {1'b0, b};
      ALU_INC:    wide = {1'b0, a} + {{DW{1'b0}}, 1'b1};
      ALU_ADD:    wide = {1'b0, a} + {1'b0, b};
      ALU_SUB:    wide = {1'b0, a} - {1'b0, b};
      default:    wide = {1'b0, a};
    endcase
  end

  assign result = wide[DW-1:0];
  assign carry  = wide[DW];
  assign zero   = (wide[DW-1:0] == '0);

endmodule

// File: rtl/acc_cpu_p.sv
// Multi-cycle single-accumulator CPU with Z/C flags and a stalling memory port.
// Define ACC_CPU_P_ILLEGAL_TRAP_EN to trap undefined opcodes into HLT with illegal=1.
//
// state | meaning
// F0    | mar <- pr
// F1    | pr <- pr+1, start opcode read
// F2    | ir <- mem[mar], wait for mem_ready
// DEC   | decode: NOP->F0, HALT->HLT, operand ops -> mar <- pr
// O1    | pr <- pr+1, start operand read
// O2    | operand arrives: immediate/jump finish, memory ops latch address
// EX    | LD/ADD/SUB read or ST write, wait for mem_ready
// HLT   | stopped, no memory traffic, leave only by reset
module acc_cpu_p
  import acc_cpu_p_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] adrs,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          mem_read,
  output logic          mem_write,
  input  logic          mem_ready,
  output logic [AW-1:0] pr,
  output logic [AW-1:0] mar,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] gr,
  output logic [1:0]    flags,
  output logic [2:0]    sc,
  output logic          halted,
  output logic          illegal
);

  state_t        state;
  logic [3:0]    op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          alu_z;
  alu_op_t       alu_op;

  assign op   = ir[3:0];
  assign sc   = state;
  assign adrs = (mem_read | mem_write) ? mar : '0;
  assign dout = mem_write ? gr : '0;

  // The ALU also serves as the PR incrementer; truncation gives the 2^AW wrap.
  always_comb begin
    alu_a  = gr;
    alu_op = ALU_PASS_A;
    if (state == ST_F1 || state == ST_O1) begin
      alu_a  = DW'(pr);
      alu_op = ALU_INC;
    end else begin
      case (op)
        OP_LDI, OP_LD:   alu_op = ALU_PASS_B;
        OP_ADDI, OP_ADD: alu_op = ALU_ADD;
        OP_SUBI, OP_SUB: alu_op = ALU_SUB;
        default:         alu_op = ALU_PASS_A;
      endcase
    end
  end

  acc_cpu_p_alu #(.DW(DW)) u_alu (
    .a      (alu_a),
    .b      (din),
    .op     (alu_op),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

`ifdef ACC_CPU_P_ILLEGAL_TRAP_EN
  logic trap;
  assign illegal = trap;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_F0;
      pr        <= '0;
      mar       <= '0;
      ir        <= '0;
      gr        <= '0;
      flags     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      halted    <= 1'b0;
`ifdef ACC_CPU_P_ILLEGAL_TRAP_EN
      trap      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_F0: begin
          mar   <= pr;
          state <= ST_F1;
        end
        ST_F1: begin
          pr       <= alu_res[AW-1:0];
          mem_read <= 1'b1;
          state    <= ST_F2;
        end
        ST_F2: begin
          if (mem_ready) begin
            ir       <= din;
            mem_read <= 1'b0;
            state    <= ST_DEC;
          end
        end
        ST_DEC: begin
          if (op == OP_NOP) begin
            state <= ST_F0;
          end else if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HLT;
          end else if (has_operand(op)) begin
            mar   <= pr;
            state <= ST_O1;
          end else begin
`ifdef ACC_CPU_P_ILLEGAL_TRAP_EN
            trap   <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HLT;
`else
            state  <= ST_F0;
`endif
          end
        end
        ST_O1: begin
          pr       <= alu_res[AW-1:0];
          mem_read <= 1'b1;
          state    <= ST_O2;
        end
        ST_O2: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= ST_F0;
            case (op)
              OP_LDI, OP_ADDI, OP_SUBI: begin
                gr    <= alu_res;
                flags <= {alu_c, alu_z};
              end
              OP_JUMP: pr <= din[AW-1:0];
              OP_JZ:   if (flags[0]) pr <= din[AW-1:0];
              OP_JC:   if (flags[1]) pr <= din[AW-1:0];
              OP_ST: begin
                mar       <= din[AW-1:0];
                mem_write <= 1'b1;
                state     <= ST_EX;
              end
              OP_LD, OP_ADD, OP_SUB: begin
                mar      <= din[AW-1:0];
                mem_read <= 1'b1;
                state    <= ST_EX;
              end
              default: ;
            endcase
          end
        end
        ST_EX: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= ST_F0;
            if (op != OP_ST) begin
              gr    <= alu_res;
              flags <= {alu_c, alu_z};
            end
          end
        end
        ST_HLT: ;
        default: state <= ST_F0;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_p.sv
// Scoreboard bench for acc_cpu_p: an ISA-level model queues the expected state
// at each instruction retirement and each memory write; a monitor pops and compares.
module tb_acc_cpu_p;

  typedef struct {
    int pr;
    int gr;
    int c;
    int z;
    int halted;
    int illegal;
  } exp_t;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adrs, din, dout, pr, mar, ir, gr;
  logic        mem_read, mem_write, mem_ready, halted, illegal;
  logic [1:0]  flags;
  logic [2:0]  sc;

  logic        rst_w;
  logic [9:0]  adrs_w, pr_w, mar_w;
  logic [15:0] din_w, dout_w, ir_w, gr_w;
  logic        mem_read_w, mem_write_w, ready_w, halted_w, illegal_w;
  logic [1:0]  flags_w;
  logic [2:0]  sc_w;

  logic [7:0]  img [256];
  logic [7:0]  mem [256];
  logic [15:0] img16 [1024];

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;
  bit   sb_en = 1'b0;
  bit   model_halts = 1'b0;
  logic [2:0] prev_sc = 3'd0;
  bit   pend = 1'b0;
  logic pend_rd, pend_wr;
  logic [7:0] pend_a, pend_d;

  always #5 clk = ~clk;

  acc_cpu_p #(.DW(8), .AW(8)) u_dut (
    .clk(clk), .rst(rst), .adrs(adrs), .din(din), .dout(dout),
    .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
    .pr(pr), .mar(mar), .ir(ir), .gr(gr), .flags(flags), .sc(sc),
    .halted(halted), .illegal(illegal)
  );

  acc_cpu_p #(.DW(16), .AW(10)) u_dut_wide (
    .clk(clk), .rst(rst_w), .adrs(adrs_w), .din(din_w), .dout(dout_w),
    .mem_read(mem_read_w), .mem_write(mem_write_w), .mem_ready(ready_w),
    .pr(pr_w), .mar(mar_w), .ir(ir_w), .gr(gr_w), .flags(flags_w), .sc(sc_w),
    .halted(halted_w), .illegal(illegal_w)
  );

  // Memory reloads from the program image while the core is held in reset.
  assign din     = mem[adrs];
  assign din_w   = img16[adrs_w];
  assign ready_w = 1'b1;

  always @(posedge clk) begin
    if (!rst) mem <= img;
    else if (mem_write && mem_ready) mem[adrs] <= dout;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Instruction-level reference: runs the program image, queues expectations.
  function automatic void model(input int max_instr);
    int mm[256];
    int pc, acc, c, z, op, opd, t, n;
    bit stop;
    exp_t e;
    for (int i = 0; i < 256; i++) mm[i] = int'(img[i]);
    pc = 0; acc = 0; c = 0; z = 0; n = 0; stop = 1'b0;
    model_halts = 1'b0;
    while (!stop && n < max_instr) begin
      e.halted = 0;
      e.illegal = 0;
      op = mm[pc] % 16;
      pc = (pc + 1) % 256;
      opd = 0;
      if (op >= 1 && op <= 10) begin
        opd = mm[pc];
        pc = (pc + 1) % 256;
      end
      case (op)
        1: begin acc = opd; c = 0; end
        2: begin acc = mm[opd]; c = 0; end
        3, 4: begin
          t = acc + ((op == 3) ? opd : mm[opd]);
          c = (t > 255) ? 1 : 0;
          acc = t % 256;
        end
        7, 8: begin
          t = (op == 7) ? opd : mm[opd];
          c = (t > acc) ? 1 : 0;
          acc = (acc - t + 256) % 256;
        end
        5: begin
          wr_t w;
          mm[opd] = acc;
          w.a = opd;
          w.d = acc;
          wr_q.push_back(w);
        end
        6: pc = opd;
        9: if (z != 0) pc = opd;
        10: if (c != 0) pc = opd;
        15: begin e.halted = 1; stop = 1'b1; end
        11, 12, 13, 14: begin
`ifdef ACC_CPU_P_ILLEGAL_TRAP_EN
          e.halted = 1;
          e.illegal = 1;
          stop = 1'b1;
`endif
        end
        default: ;
      endcase
      if (op == 1 || op == 2 || op == 3 || op == 4 || op == 7 || op == 8)
        z = (acc == 0) ? 1 : 0;
      e.pr = pc;
      e.gr = acc;
      e.c = c;
      e.z = z;
      exp_q.push_back(e);
      model_halts = stop;
      n++;
    end
  endfunction

  // Monitor: bus rules, stall stability, write and retirement scoreboard.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    #2;
    if (!rst) begin
      prev_sc = 3'd0;
      pend = 1'b0;
    end else begin
      checks++;
      if ((mem_read && mem_write) || (!(mem_read || mem_write) && adrs !== 8'h00) ||
          (!mem_write && dout !== 8'h00)) begin
        errors++;
        $display("FAIL bus: rd=%0b wr=%0b adrs=%0h dout=%0h, want exclusive requests and zero idle bus",
                 mem_read, mem_write, adrs, dout);
      end
      if (pend) begin
        checks++;
        if (mem_read !== pend_rd || mem_write !== pend_wr || adrs !== pend_a || dout !== pend_d) begin
          errors++;
          $display("FAIL stall_hold: got rd=%0b wr=%0b adrs=%0h dout=%0h want rd=%0b wr=%0b adrs=%0h dout=%0h",
                   mem_read, mem_write, adrs, dout, pend_rd, pend_wr, pend_a, pend_d);
        end
      end
      pend = (mem_read || mem_write) && !mem_ready;
      pend_rd = mem_read; pend_wr = mem_write; pend_a = adrs; pend_d = dout;
      if (sb_en && mem_write && mem_ready) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected write adrs=%0h dout=%0h, want none", adrs, dout);
        end else begin
          w = wr_q.pop_front();
          if (adrs !== w.a[7:0] || dout !== w.d[7:0]) begin
            errors++;
            $display("FAIL write: got adrs=%0h dout=%0h want adrs=%0h dout=%0h", adrs, dout, w.a, w.d);
          end
        end
      end
      if (sb_en && ((sc == 3'd0 && prev_sc != 3'd0) || (sc == 3'd7 && prev_sc != 3'd7))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL retire: unexpected retirement pr=%0h sc=%0d, want none", pr, sc);
        end else begin
          e = exp_q.pop_front();
          if (pr !== e.pr[7:0] || gr !== e.gr[7:0] || flags !== {e.c[0], e.z[0]} ||
              halted !== e.halted[0] || illegal !== e.illegal[0]) begin
            errors++;
            $display("FAIL retire: got pr=%0h gr=%0h cz=%b h=%0b il=%0b want pr=%0h gr=%0h cz=%0d%0d h=%0d il=%0d",
                     pr, gr, flags, halted, illegal, e.pr, e.gr, e.c, e.z, e.halted, e.illegal);
          end
        end
      end
      prev_sc = sc;
    end
  end

  // Ready driver: 0 always ready, 1 random, 2 stall each access 3 cycles, 3 stall writes forever.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    mem_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (rst && (mem_read || mem_write) && stall_cnt < 3) begin
            mem_ready = 1'b0;
            stall_cnt++;
          end else begin
            mem_ready = 1'b1;
            stall_cnt = 0;
          end
        end
        default: mem_ready = !mem_write;
      endcase
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // Returns the number of clock edges from reset release to the last expected retirement.
  task automatic run_prog(input int mode, input int max_instr, output int cyc);
    rst = 1'b0;
    sb_en = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    exp_q.delete();
    wr_q.delete();
    model(max_instr);
    rdy_mode = mode;
    sb_en = 1'b1;
    rst = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d retirements and %0d writes outstanding after %0d cycles, want 0",
               exp_q.size(), wr_q.size(), cyc);
    end
    if (model_halts && exp_q.size() == 0) begin
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (halted !== 1'b1 || sc !== 3'd7 || mem_read || mem_write) begin
        errors++;
        $display("FAIL hlt_hold: got halted=%0b sc=%0d rd=%0b wr=%0b want halted=1 sc=7 no access",
                 halted, sc, mem_read, mem_write);
      end
    end
    sb_en = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc;
    rst = 1'b0;
    rst_w = 1'b0;
    clear_img();
    for (int i = 0; i < 1024; i++) img16[i] = 16'h0000;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_regs", int'({pr, mar, ir, gr}), 0);
    chk("reset_ctl", int'({flags, sc, mem_read, mem_write, halted, illegal}), 0);

    // LDI 05; ADDI 03; ST 20; HALT: 6+6+7+4 edges until HLT
    clear_img();
    img[0] = 8'h01; img[1] = 8'h05; img[2] = 8'h03; img[3] = 8'h03;
    img[4] = 8'h05; img[5] = 8'h20; img[6] = 8'h0F;
    run_prog(0, 50, cyc);
    chk("t1_cycles", cyc, 23);
    chk("t1_mem20", int'(mem[8'h20]), 8'h08);

    // LDI FF; ADDI 01 (Z=1,C=1); JZ 10 taken; LDI 01 (C=0); JC 30 not taken; HALT
    clear_img();
    img[0] = 8'h01; img[1] = 8'hFF; img[2] = 8'h03; img[3] = 8'h01;
    img[4] = 8'h09; img[5] = 8'h10; img[8'h10] = 8'h01; img[8'h11] = 8'h01;
    img[8'h12] = 8'h0A; img[8'h13] = 8'h30; img[8'h14] = 8'h0F;
    run_prog(1, 50, cyc);
    chk("t2_pr_after_jc", int'(pr), 8'h15);

    // LDI 03; SUB [40]=05 -> FE with borrow; ST 41; HALT
    clear_img();
    img[0] = 8'h01; img[1] = 8'h03; img[2] = 8'h08; img[3] = 8'h40;
    img[4] = 8'h05; img[5] = 8'h41; img[6] = 8'h0F; img[8'h40] = 8'h05;
    run_prog(0, 50, cyc);
    chk("t3_mem41", int'(mem[8'h41]), 8'hFE);
    chk("t3_flags", int'(flags), 2'b10);

    // every access stalled 3 cycles: 17 base edges + 6 accesses * 3
    clear_img();
    img[0] = 8'h01; img[1] = 8'h05; img[2] = 8'h05; img[3] = 8'h20; img[4] = 8'h0F;
    run_prog(2, 50, cyc);
    chk("t4_cycles", cyc, 35);
    chk("t4_mem20", int'(mem[8'h20]), 8'h05);

    // undefined opcode 0xB followed by HALT
    clear_img();
    img[0] = 8'h0B; img[1] = 8'h0F;
    run_prog(0, 50, cyc);
`ifdef ACC_CPU_P_ILLEGAL_TRAP_EN
    chk("t5_trap", int'({illegal, halted, pr}), {1'b1, 1'b1, 8'h01});
`else
    chk("t5_notrap", int'({illegal, halted, pr}), {1'b0, 1'b1, 8'h02});
`endif

    // reset while ST is stuck in EX
    clear_img();
    img[0] = 8'h01; img[1] = 8'h05; img[2] = 8'h05; img[3] = 8'h20; img[4] = 8'h0F;
    rst = 1'b0;
    rdy_mode = 3;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
    cyc = 0;
    while (!mem_write && cyc < 50) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    repeat (2) @(negedge clk);
    #3;
    chk("t6_stuck", int'({mem_write, adrs, dout, pr, gr}), {1'b1, 8'h20, 8'h05, 8'h04, 8'h05});
    rst = 1'b0;
    #1;
    chk("t6_async_clear", int'({mem_read, mem_write, pr, mar, ir, gr, flags, sc}), 0);
    rdy_mode = 0;
    @(negedge clk);
    #3;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("t6_refetch", int'({mem_read, adrs, pr}), {1'b1, 8'h00, 8'h01});

    // DW=16, AW=10: JUMP 3FF then NOP at 3FF wraps pr to 0
    img16[0] = 16'h0006;
    img16[1] = 16'h03FF;
    @(negedge clk);
    #3;
    rst_w = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("t7_jump", int'({sc_w, pr_w}), {3'd0, 10'h3FF});
    repeat (4) @(negedge clk);
    #3;
    chk("t7_wrap", int'({sc_w, pr_w, mar_w, halted_w, illegal_w}), {3'd0, 10'h000, 10'h3FF, 2'b00});

    // random memory images, random opcodes and operands, varied ready behaviour
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
      run_prog(r % 3, 40, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
